// File: rtl/polar_pkg.sv
// polar_pkg: shared polar-code constants, info-set masks and decoder FSM states
package polar_pkg;
  localparam int N       = 1024;
  localparam int N_LOG2  = 10;
  localparam int K_R14   = 256;
  localparam int K_R38   = 384;
  localparam int K_MAX   = K_R38;
  localparam int CHUNK_W = 64;
  localparam int N_CHUNK = N / CHUNK_W;
  typedef enum logic [1:0] {IDLE, XFORM, EXTRACT, DONE} state_t;
  // Reliability order: higher Hamming weight of the index first, ties broken by
  // higher index. The top-K set then has a closed form for both rates.
  function automatic logic [N-1:0] gen_mask(input logic r38);
    logic [N-1:0] m;
    logic [N_LOG2-1:0] idx;
    int w;
    m = '0;
    for (int h = 0; h < 32; h++)
      for (int l = 0; l < 32; l++) begin
        idx = N_LOG2'(h * 32 + l);
        w = $countones(idx);
        m[h * 32 + l] = r38 ? (w >= 6 && idx != 10'd63 && idx != 10'd95)
                            : (w >= 7 || (w == 6 && idx >= 10'd736));
      end
    return m;
  endfunction
  localparam logic [N-1:0] INFO_MASK_256 = gen_mask(1'b0);
  localparam logic [N-1:0] INFO_MASK_384 = gen_mask(1'b1);
endpackage

// File: rtl/polar_dec_hard_compact.sv
// polar_info_compact: appends the info bits of one 64-bit chunk to the output accumulator
module polar_info_compact
  import polar_pkg::*;
(
  input  logic [CHUNK_W-1:0] data,
  input  logic [CHUNK_W-1:0] mask,
  input  logic [K_MAX-1:0]   acc,
  input  logic [8:0]         wr,
  output logic [K_MAX-1:0]   acc_nx,
  output logic [8:0]         wr_nx
);
  // scatter selected bits onto consecutive slots; write index ends at wr + popcount(mask)
  always_comb begin
    acc_nx = acc;
    wr_nx = wr;
    for (int b = 0; b < CHUNK_W; b++)
      if (mask[b]) begin
        acc_nx[wr_nx] = data[b];
        wr_nx = wr_nx + 9'd1;
      end
  end
endmodule

// File: rtl/polar_dec_hard.sv
// polar_dec_hard: hard-decision polar decoder (inverse transform + info-bit compaction); POLAR_DEC_FROZEN_CHK_EN adds the frozen-bit check
module polar_dec_hard
  import polar_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             polar_rate_sel,
  input  logic             polar_dec_start,
  input  logic [N-1:0]     polar_dec_data_in,
  output logic             polar_dec_busy,
  output logic             polar_dec_done,
  output logic [K_MAX-1:0] polar_dec_data_dout,
  output logic             polar_dec_frozen_err
);
  state_t state, state_nx;
  logic [N-1:0] v, v_x, mask;
  logic rate;
  logic [3:0] stage, chunk;
  logic [K_MAX-1:0] acc, acc_nx;
  logic [8:0] wr, wr_nx;
  logic [CHUNK_W-1:0] chunk_v, chunk_m;
  assign polar_dec_busy = state != IDLE;
  assign mask = rate ? INFO_MASK_384 : INFO_MASK_256;
  assign chunk_v = v[{chunk, 6'd0} +: CHUNK_W];
  assign chunk_m = mask[{chunk, 6'd0} +: CHUNK_W];
  // one butterfly stage: v[j] ^= v[j + 2^stage] wherever bit 'stage' of j is clear
  for (genvar j = 0; j < N; j++) begin : g_bf
    logic [N_LOG2-1:0] p;
    for (genvar s = 0; s < N_LOG2; s++) begin : g_s
      if (((j >> s) & 1) == 0) begin : g_pair
        assign p[s] = v[j + (1 << s)];
      end else begin : g_top
        assign p[s] = 1'b0;
      end
    end
    assign v_x[j] = v[j] ^ p[stage];
  end
  polar_info_compact u_compact (
    .data   (chunk_v),
    .mask   (chunk_m),
    .acc    (acc),
    .wr     (wr),
    .acc_nx (acc_nx),
    .wr_nx  (wr_nx)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // sequencing: ten transform stages, sixteen extract chunks, one publish cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = polar_dec_start ? XFORM : IDLE;
      XFORM:   state_nx = stage == 4'(N_LOG2 - 1) ? EXTRACT : XFORM;
      EXTRACT: state_nx = chunk == 4'(N_CHUNK - 1) ? DONE : EXTRACT;
      default: state_nx = IDLE;
    endcase
  end
  // work register, counters, accumulator and published result
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      rate <= 1'b0;
      stage <= '0;
      chunk <= '0;
      acc <= '0;
      wr <= '0;
      polar_dec_done <= 1'b0;
      polar_dec_data_dout <= '0;
    end else begin
      polar_dec_done <= state == DONE;
      case (state)
        IDLE: if (polar_dec_start) begin
          v <= polar_dec_data_in;
          rate <= polar_rate_sel;
          stage <= '0;
          chunk <= '0;
          acc <= '0;
          wr <= '0;
        end
        XFORM: begin
          v <= v_x;
          stage <= stage + 4'd1;
        end
        EXTRACT: begin
          acc <= acc_nx;
          wr <= wr_nx;
          chunk <= chunk + 4'd1;
        end
        default: polar_dec_data_dout <= rate ? acc : {{(K_MAX - K_R14){1'b0}}, acc[K_R14-1:0]};
      endcase
    end
`ifdef POLAR_DEC_FROZEN_CHK_EN
  logic frz;
  // sticky flag of any nonzero frozen position, published alongside the data
  always_ff @(posedge clk)
    if (rst) begin
      frz <= 1'b0;
      polar_dec_frozen_err <= 1'b0;
    end else begin
      if (state == IDLE && polar_dec_start) frz <= 1'b0;
      else if (state == EXTRACT) frz <= frz | (|(chunk_v & ~chunk_m));
      if (state == DONE) polar_dec_frozen_err <= frz;
    end
`else
  assign polar_dec_frozen_err = 1'b0;
`endif
endmodule

// File: tb/tb_polar_dec_hard.sv
// tb_polar_dec_hard: randomized self-checking bench with a subset-sum reference model
module tb_polar_dec_hard;
  import polar_pkg::*;
  typedef struct {
    int due;
    logic [K_MAX-1:0] dout;
    logic ferr;
  } exp_t;
`ifdef POLAR_DEC_FROZEN_CHK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif
  logic clk = 0, rst = 1, rate_sel = 0, start = 0;
  logic [N-1:0] data_in = '0;
  logic busy, done, ferr;
  logic [K_MAX-1:0] dout;
  int n_chk = 0, n_fail = 0, ecnt = 0, free_at = 0, busy_from = 0, busy_to = 0;
  bit chk_on = 0;
  exp_t q[$];
  logic [K_MAX-1:0] exp_dout = '0;
  logic exp_ferr = 0;
  logic [N-1:0] m256, m384;

  polar_dec_hard dut (
    .clk                  (clk),
    .rst                  (rst),
    .polar_rate_sel       (rate_sel),
    .polar_dec_start      (start),
    .polar_dec_data_in    (data_in),
    .polar_dec_busy       (busy),
    .polar_dec_done       (done),
    .polar_dec_data_dout  (dout),
    .polar_dec_frozen_err (ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [K_MAX-1:0] act, input logic [K_MAX-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // u_j = XOR of x_i over every i whose bit set contains j's (G is an involution)
  function automatic logic [N-1:0] u_of(input logic [N-1:0] x);
    logic [N-1:0] u;
    for (int j = 0; j < N; j++) begin
      u[j] = 1'b0;
      for (int i = j; i < N; i++)
        if ((i & j) == j) u[j] ^= x[i];
    end
    return u;
  endfunction

  // top-k positions ranked by index weight (descending), then index (descending)
  function automatic logic [N-1:0] ref_mask(input int k);
    logic [N-1:0] m;
    int c;
    m = '0;
    c = 0;
    for (int w = N_LOG2; w >= 0; w--)
      for (int i = N - 1; i >= 0; i--)
        if (c < k && $countones(10'(i)) == w) begin
          m[i] = 1'b1;
          c++;
        end
    return m;
  endfunction

  function automatic logic [N-1:0] rnd_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic accept(input logic [N-1:0] x, input logic r, input int e);
    logic [N-1:0] u, m;
    exp_t t;
    int k;
    u = u_of(x);
    m = r ? m384 : m256;
    t.due = e + 27;
    t.dout = '0;
    t.ferr = 1'b0;
    k = 0;
    for (int i = 0; i < N; i++)
      if (m[i]) begin
        t.dout[k] = u[i];
        k++;
      end else t.ferr |= u[i];
    t.ferr &= FCHK;
    q.push_back(t);
    busy_from = e;
    busy_to = e + 27;
    free_at = e + 28;
  endtask

  // one cycle of stimulus, entered and left at a falling edge
  task automatic step(input logic st, input logic [N-1:0] x, input logic r);
    int e;
    e = ecnt + 1;
    start = st;
    data_in = x;
    rate_sel = r;
    if (st && e >= free_at) accept(x, r, e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // start a word, then 27 cycles with random (ignored) start pulses; returns in the done cycle
  task automatic run_word(input logic [N-1:0] x, input logic r);
    step(1'b1, x, r);
    repeat (27) step($urandom_range(0, 3) == 0, rnd_vec(), 1'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    q.delete();
    busy_from = 0;
    busy_to = 0;
    free_at = 0;
    exp_dout = '0;
    exp_ferr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loopback(input logic r);
    logic [N-1:0] u, m;
    logic [K_MAX-1:0] info;
    int k;
    for (int w = 0; w < 10; w++) begin
      m = r ? m384 : m256;
      info = '0;
      u = '0;
      k = 0;
      for (int i = 0; i < K_MAX; i++) info[i] = (r || i < K_R14) ? 1'($urandom) : 1'b0;
      if (w == 0) info = K_MAX'(1);
      for (int i = 0; i < N; i++)
        if (m[i]) begin
          u[i] = info[k];
          k++;
        end
      run_word(u_of(u), r);
      chk("loop_done", K_MAX'(done), K_MAX'(1));
      chk("loop_dout", dout, info);
      chk("loop_ferr", K_MAX'(ferr), '0);
    end
  endtask

  // every-cycle comparison of all outputs against the scoreboard
  always @(negedge clk) begin : cmp
    bit ed;
    if (chk_on) begin
      ed = q.size() > 0 && q[0].due == ecnt;
      chk("done", K_MAX'(done), K_MAX'(ed));
      chk("busy", K_MAX'(busy), K_MAX'(busy_from <= ecnt && ecnt < busy_to));
      if (ed) begin
        exp_dout = q[0].dout;
        exp_ferr = q[0].ferr;
        void'(q.pop_front());
      end
      chk("dout", dout, exp_dout);
      chk("ferr", K_MAX'(ferr), K_MAX'(exp_ferr));
    end
  end

  initial begin
    logic [N-1:0] e0, e1023, t;
    logic [K_MAX-1:0] ones256;
    e0 = '0;
    e0[0] = 1'b1;
    e1023 = '0;
    e1023[N-1] = 1'b1;
    ones256 = '0;
    ones256[K_R14-1:0] = '1;
    m256 = ref_mask(K_R14);
    m384 = ref_mask(K_R38);
    chk("pin_m256_pop", K_MAX'($countones(m256)), K_MAX'(256));
    chk("pin_m384_pop", K_MAX'($countones(m384)), K_MAX'(384));
    chk("pin_mask_bits", K_MAX'({m256[739], m256[718], m384[718], m384[63], m384[95], m384[111], m256[0], m384[0]}),
        K_MAX'(8'b10100100));
    t = u_of(e0);
    chk("pin_u_e0", K_MAX'({t[0], 11'($countones(t))}), K_MAX'({1'b1, 11'd1}));
    t = u_of(e1023);
    chk("pin_u_e1023", K_MAX'($countones(t)), K_MAX'(1024));
    @(negedge clk);
    do_reset();
    chk_on = 1;
    run_word('0, 1'b0);
    chk("zero_done", K_MAX'(done), K_MAX'(1));
    chk("zero_dout", dout, '0);
    chk("zero_ferr", K_MAX'(ferr), '0);
    loopback(1'b0);
    loopback(1'b1);
    for (int r = 0; r < 2; r++) begin
      run_word(e0, 1'(r));
      chk("e0_dout", dout, '0);
      chk("e0_ferr", K_MAX'(ferr), K_MAX'(FCHK));
    end
    run_word(e1023, 1'b0);
    chk("e1023_dout", dout, ones256);
    chk("e1023_ferr", K_MAX'(ferr), K_MAX'(FCHK));
    repeat (6) run_word(rnd_vec(), 1'($urandom));
    step(1'b1, rnd_vec(), 1'b1);
    repeat (14) step($urandom_range(0, 1) == 0, rnd_vec(), 1'($urandom));
    do_reset();
    chk("abort_dout", dout, '0);
    chk("abort_busy", K_MAX'({busy, done, ferr}), '0);
    repeat (30) step(1'b0, '0, 1'b0);
    run_word(e1023, 1'b1);
    chk("post_rst_done", K_MAX'(done), K_MAX'(1));
    chk("post_rst_dout", dout, {K_MAX{1'b1}});
    run_word(rnd_vec(), 1'b0);
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    chk("drain", K_MAX'(q.size()), '0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
